// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, alu_result_stage and writeback.
// The master side is the environment; the slave side is the stage.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned RD_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [RD_W-1:0]  in_rd;
  logic             in_wen;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wen;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_result, in_rd, in_wen, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wen, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_result, in_rd, in_wen, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wen, out_zero, out_neg
  );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry elastic skid stage between ALU and writeback; flags computed at capture.
// Optional ALU_RESULT_STATS_EN adds a 32-bit retired-result counter output.
module alu_result_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned RD_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic [1:0]          occ,
`ifdef ALU_RESULT_STATS_EN
  output logic [31:0]         retired_count,
`endif
  alu_result_stage_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             wen;
    logic             zero;
    logic             neg;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t new_entry;
  logic   push;
  logic   pop;

  // Readiness depends on registered state only, never on out_ready.
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign occ           = state;

  assign push = bus.in_valid  & (state != FULL);
  assign pop  = bus.out_ready & (state != EMPTY);

  always_comb begin
    new_entry        = '0;
    new_entry.result = bus.in_result;
    new_entry.rd     = bus.in_rd;
    new_entry.wen    = bus.in_wen;
    new_entry.zero   = (bus.in_result == '0);
    new_entry.neg    = bus.in_result[WIDTH-1];
  end

  assign bus.out_result = head.result;
  assign bus.out_rd     = head.rd;
  assign bus.out_wen    = head.wen;
  assign bus.out_zero   = head.zero;
  assign bus.out_neg    = head.neg;

  // Shift-style storage: head feeds writeback, tail only holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head  <= new_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= new_entry;
          end else if (push) begin
            tail  <= new_entry;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (pop && !flush) begin
      retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule
